// File: rtl/div_seq_ctrl_if.sv
// Operator/divider/display bundle for the divide sequencer.
// Latency: none, this is wiring only.
// Backpressure: div_start_out is held until div_ready_in; the other signals are pulses or levels.
interface div_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              btn_pulse_in;
  logic [3:0]        sw_in;
  logic              div_ready_in;
  logic              div_start_out;
  logic [DATA_W-1:0] div_a_out;
  logic [DATA_W-1:0] div_b_out;
  logic              div_valid_in;
  logic [DATA_W-1:0] div_q_in;
  logic [DATA_W-1:0] div_r_in;
  logic [31:0]       disp_data_out;
  logic [7:0]        disp_mask_out;
  logic              valid_out_LED;
  logic              err_out;

  // Sequencer side
  modport master (
    input  btn_pulse_in, sw_in, div_ready_in, div_valid_in, div_q_in, div_r_in,
    output div_start_out, div_a_out, div_b_out, disp_data_out, disp_mask_out,
           valid_out_LED, err_out
  );

  // Environment side: buttons, switches, divider and display
  modport slave (
    output btn_pulse_in, sw_in, div_ready_in, div_valid_in, div_q_in, div_r_in,
    input  div_start_out, div_a_out, div_b_out, disp_data_out, disp_mask_out,
           valid_out_LED, err_out
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Operator sequencer: nibble entry of A/B, one divide launch, result capture, hex display.
// Latency: every output is a Moore decode of state, so it updates one cycle after the triggering edge.
// Backpressure: start is held with stable A/B until div_ready_in; button pulses are dropped in ISSUE/WAIT.
module div_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  div_seq_ctrl_if.master bus
);
  localparam int             NIBS     = DATA_W / 4;
  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [1:0]     CNT_LAST = 2'(NIBS - 1);
  localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);
  // A sits in the most significant used digits, B just below it
  localparam logic [7:0]     MASK_A   = 8'(((1 << NIBS) - 1) << (3 * NIBS));
  localparam logic [7:0]     MASK_B   = 8'(((1 << NIBS) - 1) << (2 * NIBS));

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE,
    S_WAIT,
    S_SHOW,
    S_ERR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a, r_b, r_q, r_r;
  logic [DATA_W-1:0] w_a_nxt, w_b_nxt, w_q_nxt, w_r_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [DATA_W-1:0] w_a_shift, w_b_shift;

  // New nibble enters at the bottom; the top nibble falls off (whole word when DATA_W=4)
  assign w_a_shift = DATA_W'({r_a, bus.sw_in});
  assign w_b_shift = DATA_W'({r_b, bus.sw_in});

  // State and operand/result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next-state and register updates; anything not handled in a state holds
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    case (r_state)
      S_LOAD_A: begin
        if (bus.btn_pulse_in) begin
          w_a_nxt = w_a_shift;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_LOAD_B;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      S_LOAD_B: begin
        if (bus.btn_pulse_in) begin
          w_b_nxt = w_b_shift;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            // Zero divisor never reaches the divider
            w_state_nxt = (w_b_shift == '0) ? S_ERR : S_ISSUE;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      S_ISSUE: begin
        if (bus.div_ready_in) begin
          w_timer_nxt = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result landing on the expiry cycle still counts
        if (bus.div_valid_in) begin
          w_q_nxt     = bus.div_q_in;
          w_r_nxt     = bus.div_r_in;
          w_state_nxt = S_SHOW;
        end else if (r_timer == T_LAST) begin
          w_state_nxt = S_ERR;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_SHOW, S_ERR: begin
        if (bus.btn_pulse_in) begin
          w_a_nxt     = '0;
          w_b_nxt     = '0;
          w_q_nxt     = '0;
          w_r_nxt     = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOAD_A;
        end
      end
      default: w_state_nxt = S_LOAD_A;
    endcase
  end

  // Moore output decode from registered state
  always_comb begin
    bus.div_start_out = (r_state == S_ISSUE);
    bus.div_a_out     = r_a;
    bus.div_b_out     = r_b;
    bus.valid_out_LED = (r_state == S_SHOW);
    bus.err_out       = (r_state == S_ERR);
    bus.disp_data_out = 32'({r_a, r_b, r_q, r_r});
    bus.disp_mask_out = 8'h00;
    case (r_state)
      S_LOAD_A:                  bus.disp_mask_out = (r_cnt != 2'd0) ? MASK_A : 8'h00;
      S_LOAD_B, S_ISSUE, S_WAIT: bus.disp_mask_out = MASK_A | MASK_B;
      S_SHOW:                    bus.disp_mask_out = 8'hFF;
      S_ERR: begin
        bus.disp_mask_out = 8'hFF;
        bus.disp_data_out = 32'hEEEE_EEEE;
      end
      default:                   bus.disp_mask_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;
  localparam int DW = 8;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  div_seq_ctrl_if #(.DATA_W(DW)) bus();

  div_seq_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.btn_pulse_in = 1'b0;
    bus.sw_in        = 4'h0;
    bus.div_ready_in = 1'b0;
    bus.div_valid_in = 1'b0;
    bus.div_q_in     = '0;
    bus.div_r_in     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the next negedge with the capture visible
  task automatic pulse_btn(input logic [3:0] nib);
    bus.sw_in        = nib;
    bus.btn_pulse_in = 1'b1;
    @(negedge clk);
    bus.btn_pulse_in = 1'b0;
  endtask

  task automatic enter_ab(input logic [7:0] a, input logic [7:0] b);
    pulse_btn(a[7:4]);
    pulse_btn(a[3:0]);
    pulse_btn(b[7:4]);
    pulse_btn(b[3:0]);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.div_start_out, bus.valid_out_LED, bus.err_out, bus.disp_mask_out} !== 11'h0) begin
      failures++;
      $display("FAIL reset_ctrl: got start=%b led=%b err=%b mask=%h want all 0",
               bus.div_start_out, bus.valid_out_LED, bus.err_out, bus.disp_mask_out);
    end
    checks++;
    if ({bus.disp_data_out, bus.div_a_out, bus.div_b_out} !== 48'h0) begin
      failures++;
      $display("FAIL reset_data: got disp=%h a=%h b=%h want 0",
               bus.disp_data_out, bus.div_a_out, bus.div_b_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.disp_data_out, bus.disp_mask_out, bus.div_start_out} !== 41'h0) begin
      failures++;
      $display("FAIL reset_release: got disp=%h mask=%h start=%b want 0",
               bus.disp_data_out, bus.disp_mask_out, bus.div_start_out);
    end
  endtask

  // Full divide: entry, start held rdly cycles without ready, result after vdly WAIT cycles
  task automatic test_divide(input logic [7:0] a, input logic [7:0] b, input int rdly, input int vdly);
    logic [7:0] q, r;
    logic       bad;
    q = a / b;
    r = a % b;
    pulse_btn(a[7:4]);
    checks++;
    if (bus.disp_mask_out !== 8'hC0 || bus.disp_data_out[31:24] !== {4'h0, a[7:4]}) begin
      failures++;
      $display("FAIL first_nibble: got mask=%h disp=%h want mask=c0 top=%h",
               bus.disp_mask_out, bus.disp_data_out, {4'h0, a[7:4]});
    end
    pulse_btn(a[3:0]);
    checks++;
    if (bus.disp_mask_out !== 8'hF0 || bus.div_a_out !== a) begin
      failures++;
      $display("FAIL a_loaded: got mask=%h a=%h want mask=f0 a=%h", bus.disp_mask_out, bus.div_a_out, a);
    end
    pulse_btn(b[7:4]);
    pulse_btn(b[3:0]);
    for (int i = 0; i <= rdly; i++) begin
      if (i == rdly) bus.div_ready_in = 1'b1;
      checks++;
      if ({bus.div_start_out, bus.div_a_out, bus.div_b_out} !== {1'b1, a, b}) begin
        failures++;
        $display("FAIL issue_hold[%0d]: got start=%b a=%h b=%h want 1 %h %h",
                 i, bus.div_start_out, bus.div_a_out, bus.div_b_out, a, b);
      end
      @(negedge clk);
    end
    bus.div_ready_in = 1'b0;
    checks++;
    if (bus.div_start_out !== 1'b0 || bus.disp_mask_out !== 8'hF0) begin
      failures++;
      $display("FAIL start_drop: got start=%b mask=%h want 0 f0", bus.div_start_out, bus.disp_mask_out);
    end
    bad = 1'b0;
    repeat (vdly) begin
      if (bus.valid_out_LED !== 1'b0 || bus.err_out !== 1'b0 || bus.div_start_out !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL wait_quiet: led/err/start toggled while waiting (vdly=%0d)", vdly);
    end
    bus.div_valid_in = 1'b1;
    bus.div_q_in     = q;
    bus.div_r_in     = r;
    @(negedge clk);
    bus.div_valid_in = 1'b0;
    bus.div_q_in     = 8'($urandom);
    bus.div_r_in     = 8'($urandom);
    checks++;
    if (bus.disp_data_out !== {a, b, q, r} || bus.disp_mask_out !== 8'hFF ||
        bus.valid_out_LED !== 1'b1 || bus.err_out !== 1'b0) begin
      failures++;
      $display("FAIL show: got disp=%h mask=%h led=%b err=%b want %h ff 1 0",
               bus.disp_data_out, bus.disp_mask_out, bus.valid_out_LED, bus.err_out, {a, b, q, r});
    end
    pulse_btn(4'($urandom));
    checks++;
    if ({bus.disp_data_out, bus.disp_mask_out, bus.valid_out_LED, bus.div_a_out, bus.div_b_out} !== 57'h0) begin
      failures++;
      $display("FAIL show_clear: got disp=%h mask=%h led=%b a=%h b=%h want 0",
               bus.disp_data_out, bus.disp_mask_out, bus.valid_out_LED, bus.div_a_out, bus.div_b_out);
    end
  endtask

  task automatic test_back_to_back(input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      test_divide(a, b, $urandom_range(0, 6), (k == 0) ? TO - 1 : $urandom_range(0, TO - 1));
    end
  endtask

  task automatic test_div_zero();
    logic bad;
    do_reset();
    bad = 1'b0;
    pulse_btn(4'h1); bad |= bus.div_start_out;
    pulse_btn(4'h2); bad |= bus.div_start_out;
    pulse_btn(4'h0); bad |= bus.div_start_out;
    pulse_btn(4'h0);
    checks++;
    if (bus.err_out !== 1'b1 || bus.disp_data_out !== 32'hEEEE_EEEE || bus.disp_mask_out !== 8'hFF) begin
      failures++;
      $display("FAIL div_zero: got err=%b disp=%h mask=%h want 1 eeeeeeee ff",
               bus.err_out, bus.disp_data_out, bus.disp_mask_out);
    end
    repeat (4) begin
      bad |= bus.div_start_out;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL div_zero_start: got start asserted want never");
    end
    pulse_btn(4'h9);
    checks++;
    if ({bus.err_out, bus.disp_data_out, bus.disp_mask_out, bus.div_a_out} !== 49'h0) begin
      failures++;
      $display("FAIL div_zero_clear: got err=%b disp=%h mask=%h a=%h want 0",
               bus.err_out, bus.disp_data_out, bus.disp_mask_out, bus.div_a_out);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] a, b;
    do_reset();
    a = 8'($urandom);
    b = 8'($urandom_range(1, 255));
    enter_ab(a, b);
    bus.div_ready_in = 1'b1;
    @(negedge clk);
    bus.div_ready_in = 1'b0;
    repeat (TO - 1) @(negedge clk);
    checks++;
    if (bus.err_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got err=%b one cycle before expiry want 0", bus.err_out);
    end
    @(negedge clk);
    checks++;
    if (bus.err_out !== 1'b1 || bus.disp_data_out !== 32'hEEEE_EEEE || bus.valid_out_LED !== 1'b0) begin
      failures++;
      $display("FAIL timeout: got err=%b disp=%h led=%b want 1 eeeeeeee 0",
               bus.err_out, bus.disp_data_out, bus.valid_out_LED);
    end
    bus.div_valid_in = 1'b1;
    bus.div_q_in     = 8'h5A;
    @(negedge clk);
    bus.div_valid_in = 1'b0;
    checks++;
    if (bus.err_out !== 1'b1 || bus.valid_out_LED !== 1'b0) begin
      failures++;
      $display("FAIL late_valid: got err=%b led=%b want 1 0", bus.err_out, bus.valid_out_LED);
    end
    pulse_btn(4'h3);
    checks++;
    if ({bus.err_out, bus.disp_data_out, bus.div_a_out, bus.div_b_out} !== 49'h0) begin
      failures++;
      $display("FAIL timeout_clear: got err=%b disp=%h a=%h b=%h want 0",
               bus.err_out, bus.disp_data_out, bus.div_a_out, bus.div_b_out);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] a, b;
    do_reset();
    a = 8'($urandom);
    b = 8'($urandom_range(1, 255));
    enter_ab(a, b);
    pulse_btn(~a[3:0]);
    pulse_btn(~b[3:0]);
    checks++;
    if ({bus.div_start_out, bus.div_a_out, bus.div_b_out} !== {1'b1, a, b}) begin
      failures++;
      $display("FAIL btn_in_issue: got start=%b a=%h b=%h want 1 %h %h",
               bus.div_start_out, bus.div_a_out, bus.div_b_out, a, b);
    end
    bus.div_ready_in = 1'b1;
    @(negedge clk);
    bus.div_ready_in = 1'b0;
    pulse_btn(~a[7:4]);
    checks++;
    if ({bus.div_start_out, bus.valid_out_LED, bus.err_out, bus.div_a_out, bus.div_b_out} !== {3'b000, a, b}) begin
      failures++;
      $display("FAIL btn_in_wait: got start=%b led=%b err=%b a=%h b=%h want 0 0 0 %h %h",
               bus.div_start_out, bus.valid_out_LED, bus.err_out, bus.div_a_out, bus.div_b_out, a, b);
    end
    bus.div_valid_in = 1'b1;
    bus.div_q_in     = a / b;
    bus.div_r_in     = a % b;
    @(negedge clk);
    bus.div_valid_in = 1'b0;
    checks++;
    if (bus.valid_out_LED !== 1'b1 || bus.disp_data_out !== {a, b, a / b, a % b}) begin
      failures++;
      $display("FAIL wait_result: got led=%b disp=%h want 1 %h",
               bus.valid_out_LED, bus.disp_data_out, {a, b, a / b, a % b});
    end
    pulse_btn(4'h0);
    bus.div_valid_in = 1'b1;
    bus.div_q_in     = 8'hA5;
    bus.div_r_in     = 8'h3C;
    @(negedge clk);
    bus.div_valid_in = 1'b0;
    checks++;
    if (bus.disp_data_out !== 32'h0 || bus.valid_out_LED !== 1'b0 || bus.disp_mask_out !== 8'h00) begin
      failures++;
      $display("FAIL spurious_valid: got disp=%h led=%b mask=%h want 0 0 0",
               bus.disp_data_out, bus.valid_out_LED, bus.disp_mask_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] a, b;
    do_reset();
    a = 8'($urandom);
    b = 8'($urandom_range(1, 255));
    enter_ab(a, b);
    bus.div_ready_in = 1'b1;
    @(negedge clk);
    bus.div_ready_in = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.div_start_out, bus.valid_out_LED, bus.err_out, bus.disp_mask_out,
         bus.disp_data_out, bus.div_a_out, bus.div_b_out} !== 59'h0) begin
      failures++;
      $display("FAIL async_reset: got start=%b led=%b err=%b mask=%h disp=%h a=%h b=%h want 0",
               bus.div_start_out, bus.valid_out_LED, bus.err_out, bus.disp_mask_out,
               bus.disp_data_out, bus.div_a_out, bus.div_b_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.div_valid_in = 1'b1;
    bus.div_q_in     = a / b;
    bus.div_r_in     = a % b;
    @(negedge clk);
    bus.div_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.valid_out_LED !== 1'b0 || bus.disp_data_out !== 32'h0 || bus.err_out !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_valid: got led=%b disp=%h err=%b want 0 0 0",
               bus.valid_out_LED, bus.disp_data_out, bus.err_out);
    end
  endtask

  initial begin
    test_reset();
    test_divide(8'h64, 8'h07, 0, 9);
    test_divide(8'hC8, 8'h0D, 5, 3);
    test_back_to_back(6);
    test_div_zero();
    test_timeout();
    test_ignored();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
